// File: rtl/alu_pkg.sv
// Shared types and field widths for the ALU result collector.
// Group codes follow the opcode's top two bits.
package alu_pkg;

    localparam int ALU_WIDTH = 16;
    localparam int OP_W      = 4;
    localparam int CARRY_W   = 1;

    typedef enum logic [1:0] {
        GRP_ARI   = 2'b00,
        GRP_LOG   = 2'b01,
        GRP_CMP   = 2'b10,
        GRP_SHIFT = 2'b11
    } alu_grp_e;

    function automatic alu_grp_e op_group(input logic [OP_W-1:0] op);
        return alu_grp_e'(op[3:2]);
    endfunction

endpackage

// File: rtl/alu_res_fifo.sv
// Synchronous FIFO with occupancy count; a push that finds it full with no
// simultaneous pop is dropped and reported on the drop strobe.
module alu_res_fifo #(
    parameter int W     = 21,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rest,
    input  logic                      push,
    input  logic                      pop,
    input  logic [W-1:0]              din,
    output logic [W-1:0]              dout,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          pop_ok;
    logic          push_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok = push && (!full || pop_ok);
    assign drop    = push && full && !pop_ok;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_result_collector.sv
// Collects the four ALU unit results, tags them with the delayed opcode and
// buffers them for a downstream consumer. Optional check: ALU_COLLECT_CHECK_EN.
module alu_result_collector
    import alu_pkg::*;
#(
    parameter int WIDTH  = ALU_WIDTH,
    parameter int DEPTH  = 4,
    parameter int OP_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rest,
    input  logic [3:0]             alu_fun,
    input  logic [WIDTH-1:0]       ari_out,
    input  logic [WIDTH-1:0]       log_out,
    input  logic [WIDTH-1:0]       cmp_out,
    input  logic [WIDTH-1:0]       shift_out,
    input  logic                   carry_out,
    input  logic                   ari_flag,
    input  logic                   log_flag,
    input  logic                   cmp_flag,
    input  logic                   shift_flag,
    input  logic                   err_clr,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [WIDTH-1:0]       res_data,
    output logic                   res_carry,
    output logic [3:0]             res_op,
    output logic [$clog2(DEPTH):0] count,
    output logic                   err_multi,
    output logic                   err_mismatch,
    output logic                   overflow
);

    localparam int ENTRY_W = WIDTH + CARRY_W + OP_W;

    logic [OP_W-1:0]    op_pipe [OP_LAT];
    logic [OP_W-1:0]    op_d;
    logic [WIDTH-1:0]   sel_data;
    logic               sel_carry;
    logic               any_flag;
    logic               multi;
    logic [2:0]         flag_sum;
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] head_entry;
    logic               fifo_empty;
    logic               fifo_drop;
    logic               pop;

    // Opcode delay line so the tag lines up with the unit flags.
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            for (int i = 0; i < OP_LAT; i++) begin
                op_pipe[i] <= '0;
            end
        end else begin
            op_pipe[0] <= alu_fun;
            for (int i = 1; i < OP_LAT; i++) begin
                op_pipe[i] <= op_pipe[i-1];
            end
        end
    end

    assign op_d = op_pipe[OP_LAT-1];

    assign flag_sum = 3'(ari_flag) + 3'(log_flag) + 3'(cmp_flag) + 3'(shift_flag);
    assign any_flag = (flag_sum != 3'd0);
    assign multi    = (flag_sum > 3'd1);

    always_comb begin
        sel_data  = '0;
        sel_carry = 1'b0;
        if (ari_flag) begin
            sel_data  = ari_out;
            sel_carry = carry_out;
        end else if (log_flag) begin
            sel_data = log_out;
        end else if (cmp_flag) begin
            sel_data = cmp_out;
        end else if (shift_flag) begin
            sel_data = shift_out;
        end
    end

    assign push_entry = {sel_data, sel_carry, op_d};

    // Handshake: the head entry transfers on any rising edge where
    // res_valid && res_ready; res_valid never depends on res_ready and the
    // head fields hold steady until that transfer happens.
    assign res_valid = !fifo_empty;
    assign pop       = res_valid && res_ready;

    alu_res_fifo #(
        .W     (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rest  (rest),
        .push  (any_flag),
        .pop   (pop),
        .din   (push_entry),
        .dout  (head_entry),
        .empty (fifo_empty),
        .count (count),
        .drop  (fifo_drop)
    );

    assign res_data  = head_entry[ENTRY_W-1 -: WIDTH];
    assign res_carry = head_entry[OP_W];
    assign res_op    = head_entry[OP_W-1:0];

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            err_multi <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (multi) begin
                err_multi <= 1'b1;
            end else if (err_clr) begin
                err_multi <= 1'b0;
            end
            if (fifo_drop) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
        end
    end

`ifdef ALU_COLLECT_CHECK_EN
    alu_grp_e win_grp;
    logic     mismatch;

    always_comb begin
        win_grp = GRP_ARI;
        if (ari_flag) begin
            win_grp = GRP_ARI;
        end else if (log_flag) begin
            win_grp = GRP_LOG;
        end else if (cmp_flag) begin
            win_grp = GRP_CMP;
        end else if (shift_flag) begin
            win_grp = GRP_SHIFT;
        end
    end

    assign mismatch = any_flag && (win_grp != op_group(op_d));

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            err_mismatch <= 1'b0;
        end else if (mismatch) begin
            err_mismatch <= 1'b1;
        end else if (err_clr) begin
            err_mismatch <= 1'b0;
        end
    end
`else
    assign err_mismatch = 1'b0;
`endif

endmodule
